multicycle_control: RTL and testbench

Main sequencer for the multi-cycle RV32I core. Walks each instruction through fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select, plus the 2-bit `aluop` consumed by the ALU control decoder. Talks to a single shared instruction/data memory through a req/ready handshake and watches each memory access with a timeout.

---
 rtl/riscv_ctrl_pkg.sv | 130 +++++++++++++
 rtl/mem_wait_timer.sv | 25 ++
 rtl/multicycle_control.sv | 120 ++++++++++++
 tb/tb_multicycle_control.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// rtl/riscv_ctrl_pkg.sv - shared control encodings for the multi-cycle RV32I core
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADDR,
        S_MEM_RD,
        S_LOAD_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_ILLEGAL,
        S_FAULT
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JAL    = 2'b10;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Moore part of the control word; fetch/branch mark the states whose
    // pc_write and ir_write are completed by the mem_ready and zero inputs.
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       i_or_d;
        logic       fetch;
        logic       branch;
        logic       pc_write;
        logic       reg_write;
        logic       fault;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] aluop;
        logic [1:0] wb_sel;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req   = 1'b1;
                c.fetch     = 1'b1;
                c.alu_src_a = SRC_A_PC;
                c.alu_src_b = SRC_B_FOUR;
                c.aluop     = ALUOP_ADD;
                c.pc_src    = PC_SRC_ALU;
            end
            S_DECODE: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
                c.aluop     = ALUOP_ADD;
            end
            S_EXEC_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.aluop     = ALUOP_FUNCT;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.aluop     = ALUOP_ADD;
            end
            S_ALU_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = WB_ALUOUT;
            end
            S_MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_LOAD_WB: begin
                c.reg_write = 1'b1;
                c.wb_sel    = WB_MDR;
            end
            S_MEM_WR: begin
                c.mem_req = 1'b1;
                c.mem_we  = 1'b1;
                c.i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                c.branch    = 1'b1;
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.aluop     = ALUOP_SUB;
                c.pc_src    = PC_SRC_ALUOUT;
            end
            S_JAL: begin
                c.reg_write = 1'b1;
                c.wb_sel    = WB_PC;
                c.pc_write  = 1'b1;
                c.pc_src    = PC_SRC_JAL;
            end
            S_FAULT: begin
                c.fault = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory access wait counter with all-ones expiry
module mem_wait_timer #(
    parameter int TIMEOUT_W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic wait_cycle,
    output logic expired
);

    logic [TIMEOUT_W-1:0] count;

    // Count consecutive wait cycles of the current access; clear has priority.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (wait_cycle) begin
            count <= count + 1'b1;
        end
    end

    assign expired = &count;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle RV32I main sequencer (optional ILLEGAL_TRAP_EN)
module multicycle_control
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_W = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       i_or_d,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] aluop,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       illegal,
    output logic       fault
);

    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   in_mem;
    logic   wait_cycle;
    logic   expired;

    assign in_mem     = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign wait_cycle = in_mem && !mem_ready;

    // Any non-waiting cycle clears the timer, so every new access starts at zero.
    mem_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_mem_wait_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (!wait_cycle),
        .wait_cycle (wait_cycle),
        .expired    (expired)
    );

    // Next-state selection; completion of an access wins over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    state_nxt = S_DECODE;
                else if (expired) state_nxt = S_FAULT;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:           state_nxt = S_EXEC_R;
                    OP_IMM:             state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_nxt = S_MEM_ADDR;
                    OP_BRANCH:          state_nxt = S_BRANCH;
                    OP_JAL:             state_nxt = S_JAL;
                    default:            state_nxt = S_ILLEGAL;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_nxt = S_ALU_WB;
            S_ALU_WB, S_LOAD_WB, S_BRANCH, S_JAL: state_nxt = S_FETCH;
            S_MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)    state_nxt = S_LOAD_WB;
                else if (expired) state_nxt = S_FAULT;
            end
            S_MEM_WR: begin
                if (mem_ready)    state_nxt = S_FETCH;
                else if (expired) state_nxt = S_FAULT;
            end
`ifdef ILLEGAL_TRAP_EN
            S_ILLEGAL: state_nxt = S_ILLEGAL;
`else
            S_ILLEGAL: state_nxt = S_FETCH;
`endif
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // State register with the Moore control word registered alongside it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_FETCH;
            ctrl_q <= state_ctrl(S_FETCH);
        end else begin
            state  <= state_nxt;
            ctrl_q <= state_ctrl(state_nxt);
        end
    end

    // Reset blanks every output immediately so no strobe escapes in the reset cycle.
    assign mem_req   = !reset && ctrl_q.mem_req;
    assign mem_we    = !reset && ctrl_q.mem_we;
    assign i_or_d    = !reset && ctrl_q.i_or_d;
    assign ir_write  = !reset && ctrl_q.fetch && mem_ready;
    assign pc_write  = !reset && (ctrl_q.pc_write
                                  || (ctrl_q.fetch && mem_ready)
                                  || (ctrl_q.branch && zero));
    assign reg_write = !reset && ctrl_q.reg_write;
    assign fault     = !reset && ctrl_q.fault;
    assign pc_src    = reset ? 2'b00 : ctrl_q.pc_src;
    assign alu_src_a = reset ? 2'b00 : ctrl_q.alu_src_a;
    assign alu_src_b = reset ? 2'b00 : ctrl_q.alu_src_b;
    assign aluop     = reset ? 2'b00 : ctrl_q.aluop;
    assign wb_sel    = reset ? 2'b00 : ctrl_q.wb_sel;

`ifdef ILLEGAL_TRAP_EN
    assign illegal = !reset && (state == S_ILLEGAL);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, illegal, fault;
    logic [1:0] pc_src, alu_src_a, alu_src_b, aluop, wb_sel;

    int checks = 0;
    int failures = 0;

    multicycle_control #(.TIMEOUT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .zero      (zero),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .i_or_d    (i_or_d),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .pc_src    (pc_src),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .aluop     (aluop),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .illegal   (illegal),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
                  alu_src_a, alu_src_b, aluop, reg_write, wb_sel, illegal, fault};

    function automatic logic [17:0] mk(input logic req, input logic we, input logic iod,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic rw,
                                       input logic [1:0] wb, input logic ill, input logic flt);
        return {req, we, iod, irw, pcw, psrc, a, b, op, rw, wb, ill, flt};
    endfunction

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, check the control word, then the edge follows.
    task automatic cyc(input string tag, input logic rst, input logic rdy, input logic z,
                       input logic [17:0] exp);
        @(negedge clk);
        reset     = rst;
        mem_ready = rdy;
        zero      = z;
        #1;
        check(tag, obs, exp);
    endtask

    logic [17:0] v_zero, v_fetch_w, v_fetch_r, v_dec, v_exr, v_exi, v_awb, v_mrd, v_lwb;
    logic [17:0] v_mwr, v_br1, v_br0, v_jal, v_flt, v_ill;

    initial begin
        v_zero    = '0;
        v_fetch_w = mk(1,0,0,0,0,2'b00,2'b00,2'b01,2'b00,0,2'b00,0,0);
        v_fetch_r = mk(1,0,0,1,1,2'b00,2'b00,2'b01,2'b00,0,2'b00,0,0);
        v_dec     = mk(0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,2'b00,0,0);
        v_exr     = mk(0,0,0,0,0,2'b00,2'b01,2'b00,2'b10,0,2'b00,0,0);
        v_exi     = mk(0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0,2'b00,0,0);
        v_awb     = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b00,0,0);
        v_mrd     = mk(1,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0,0);
        v_lwb     = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1,2'b01,0,0);
        v_mwr     = mk(1,1,1,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0,0);
        v_br1     = mk(0,0,0,0,1,2'b01,2'b01,2'b00,2'b01,0,2'b00,0,0);
        v_br0     = mk(0,0,0,0,0,2'b01,2'b01,2'b00,2'b01,0,2'b00,0,0);
        v_jal     = mk(0,0,0,0,1,2'b10,2'b00,2'b00,2'b00,1,2'b10,0,0);
        v_flt     = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,0,1);
        v_ill     = mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,2'b00,1,0);

        cyc("reset0", 1, 1, 1, v_zero);
        cyc("reset1", 1, 1, 0, v_zero);

        // R-type ADD, zero-wait memory: 4 cycles
        opcode = 7'b0110011;
        cyc("add_fetch", 0, 1, 0, v_fetch_r);
        cyc("add_decode", 0, 1, 0, v_dec);
        cyc("add_exec", 0, 1, 0, v_exr);
        cyc("add_wb", 0, 1, 0, v_awb);

        // LW with three wait cycles in MEM_RD: 8 cycles
        opcode = 7'b0000011;
        cyc("lw_fetch", 0, 1, 0, v_fetch_r);
        cyc("lw_decode", 0, 0, 0, v_dec);
        cyc("lw_addr", 0, 1, 0, v_exi);
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", 0, 0, 0, v_mrd);
        cyc("lw_rd_done", 0, 1, 0, v_mrd);
        cyc("lw_wb", 0, 1, 0, v_lwb);

        // SW zero-wait: 4 cycles
        opcode = 7'b0100011;
        cyc("sw_fetch", 0, 1, 0, v_fetch_r);
        cyc("sw_decode", 0, 1, 0, v_dec);
        cyc("sw_addr", 0, 1, 0, v_exi);
        cyc("sw_wr", 0, 1, 0, v_mwr);

        // BEQ taken then not taken: 3 cycles each
        opcode = 7'b1100011;
        cyc("beq1_fetch", 0, 1, 0, v_fetch_r);
        cyc("beq1_decode", 0, 1, 0, v_dec);
        cyc("beq1_branch", 0, 1, 1, v_br1);
        cyc("beq0_fetch", 0, 1, 1, v_fetch_r);
        cyc("beq0_decode", 0, 1, 1, v_dec);
        cyc("beq0_branch", 0, 1, 0, v_br0);

        // JAL: 3 cycles
        opcode = 7'b1101111;
        cyc("jal_fetch", 0, 1, 0, v_fetch_r);
        cyc("jal_decode", 0, 1, 0, v_dec);
        cyc("jal_exec", 0, 1, 0, v_jal);

        // ADDI with one fetch wait: 5 cycles
        opcode = 7'b0010011;
        cyc("addi_fetch_wait", 0, 0, 1, v_fetch_w);
        cyc("addi_fetch", 0, 1, 1, v_fetch_r);
        cyc("addi_decode", 0, 1, 0, v_dec);
        cyc("addi_exec", 0, 1, 0, v_exi);
        cyc("addi_wb", 0, 1, 0, v_awb);

        // Illegal opcode 0000000
        opcode = 7'b0000000;
        cyc("ill_fetch", 0, 1, 0, v_fetch_r);
        cyc("ill_decode", 0, 1, 0, v_dec);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc("ill_trap", 0, 1, 0, v_ill);
`else
        cyc("ill_nop", 0, 1, 0, v_zero);
        cyc("ill_refetch", 0, 0, 0, v_fetch_w);
`endif
        cyc("ill_reset", 1, 0, 0, v_zero);

        // Fetch timeout: 15 waits reach all-ones, no ready there -> FAULT
        opcode = 7'b0110011;
        for (int i = 0; i < 16; i++) cyc("to_fetch_wait", 0, 0, 0, v_fetch_w);
        cyc("to_fault", 0, 0, 0, v_flt);
        cyc("to_fault_sticky", 0, 1, 1, v_flt);
        cyc("to_fault_sticky2", 0, 1, 0, v_flt);
        cyc("to_reset", 1, 1, 0, v_zero);

        // Ready on the all-ones cycle completes the fetch
        for (int i = 0; i < 15; i++) cyc("edge_fetch_wait", 0, 0, 0, v_fetch_w);
        cyc("edge_fetch_done", 0, 1, 0, v_fetch_r);
        cyc("edge_decode", 0, 1, 0, v_dec);
        cyc("edge_exec", 0, 1, 0, v_exr);
        cyc("edge_wb", 0, 1, 0, v_awb);

        // Reset during a pending store
        opcode = 7'b0100011;
        cyc("rst_sw_fetch", 0, 1, 0, v_fetch_r);
        cyc("rst_sw_decode", 0, 1, 0, v_dec);
        cyc("rst_sw_addr", 0, 0, 0, v_exi);
        cyc("rst_sw_wr_wait", 0, 0, 0, v_mwr);
        cyc("rst_sw_in_reset", 1, 0, 0, v_zero);
        cyc("rst_sw_after", 1, 0, 0, v_zero);
        cyc("rst_refetch_wait", 0, 0, 0, v_fetch_w);
        cyc("rst_refetch", 0, 1, 0, v_fetch_r);
        cyc("rst_redecode", 0, 1, 0, v_dec);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
